shift_cmd_sequencer: RTL and testbench
======================================

# shift_cmd_sequencer

Command-driven control stage that sits directly upstream of the 4-bit bidirectional shift register and drives its `load`, `serial_input`, `direction` and `parallel_load` inputs. A single start pulse carries a complete job: a seed word, a shift direction, a shift count and the serial bits to shift in. The sequencer then emits one load cycle followed by the requested number of shift cycles, and signals completion. This replaces hand-toggling of `ui_in` pins with a deterministic, cycle-exact sequence.

## Interface
- `WIDTH`, 4, width of the seed word and of `parallel_load`; matches the shift register.
- `MAX_SHIFT`, 8, maximum shifts per job; also the width of `cmd_bits`.
- `CNT_W`, 4, width of `cmd_count`; must satisfy 2^CNT_W > MAX_SHIFT.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request; sampled on a rising edge of `clk`.
- `cmd_data`  in  WIDTH  seed word loaded into the shift register.
- `cmd_dir`  in  1  shift direction: 0 = right, 1 = left.
- `cmd_count`  in  CNT_W  number of shift cycles after the load.
- `cmd_bits`  in  MAX_SHIFT  serial bits to shift in; bit 0 is used first.
- `load`  out  1  drives the shift register's `load` input.
- `serial_input`  out  1  drives the shift register's `serial_input`.
- `direction`  out  1  drives the shift register's `direction`.
- `parallel_load`  out  WIDTH  drives the shift register's `parallel_load`.
- `busy`  out  1  high while a job is in LOAD or SHIFT.
- `done`  out  1  one-cycle pulse when a job completes.
- `start_err`  out  1  one-cycle pulse when `start` arrives while `busy` is high.

## Operation
- The state machine has four states: IDLE, LOAD, SHIFT, DONE.
- Every output comes directly from a flop; none is combinational from inputs.
- **Accept rule:** `start`=1 is accepted only when `busy`=0, i.e. in IDLE or DONE.
  - On accept, capture `cmd_data`, `cmd_dir`, `cmd_bits`, and the clamped count into internal registers.
  - Go to LOAD.
- **Count clamp:** effective count = min(`cmd_count`, MAX_SHIFT).
- **LOAD** (exactly 1 cycle):
  - `load`=1, `parallel_load`=captured data, `direction`=captured dir, `serial_input`=0, `busy`=1.
  - Next state is DONE if the count is 0, otherwise SHIFT.
- **SHIFT** (exactly count cycles):
  - `load`=0, `direction`=captured dir, `busy`=1.
  - `serial_input` = captured bits[idx]; idx starts at 0 and increments by 1 each cycle.
  - After the cycle with idx = count−1, go to DONE.
- **DONE** (1 cycle):
  - `done`=1, `busy`=0, `load`=0.
  - Next state is LOAD if `start`=1 (back-to-back job), otherwise IDLE.
- **IDLE:**
  - `load`, `serial_input`, `busy`, `done` are all 0.
  - `direction` and `parallel_load` hold their last values.
- **start_err:** asserted for one cycle following any edge where `start`=1 and `busy`=1. The job in progress is unaffected and the command is dropped.
- **Input stability:** `cmd_*` inputs are ignored except on an accept edge; changing them mid-job has no effect.

## Timing
- Start is accepted at edge t0:
  - LOAD occupies cycle t0+1.
  - SHIFT occupies cycles t0+2 … t0+1+N.
  - `done` is high in cycle t0+2+N.
  - Start-to-done latency is N+2 cycles.
- `busy` is high for exactly N+1 cycles per job.
- Back-to-back: `start` held high continuously gives one job every N+2 cycles, with no idle gap.
- **Reset** (asynchronous, any time, including mid-SHIFT):
  - State goes to IDLE immediately.
  - All outputs go to 0: `load`, `serial_input`, `direction`, `parallel_load`=0, `busy`, `done`, `start_err`.
  - idx and captured registers are cleared.
  - The first accept is possible at the first rising edge after reset deasserts.

## Test plan
- **Right shift:** reset, then start with `cmd_data`=4'b1010, `cmd_dir`=0, `cmd_count`=2, `cmd_bits`=8'h03, driving a shift-register model.
  - Required: `load` at t0+1; `serial_input`=1,1 at t0+2 and t0+3; register holds 1010 → 1101 → 1110; `done` at t0+4.
- **Zero count:** `cmd_count`=0, `cmd_data`=4'hF.
  - Required: one LOAD cycle, then `done` at t0+2; the register holds 1111.
- **Clamp:** `cmd_count`=4'd12, `cmd_dir`=1, `cmd_bits`=8'hA5.
  - Required: exactly 8 shift cycles; `serial_input` sequence 1,0,1,0,0,1,0,1; `done` at t0+10.
- **Busy collision and back-to-back:**
  - `start` pulse during SHIFT → `start_err`=1 for one cycle; the job in progress completes unchanged.
  - `start` in the DONE cycle → LOAD on the next cycle with no IDLE gap.
- **Reset mid-job:** assert `reset` during the 3rd SHIFT cycle of an 8-shift job.
  - Required: all outputs are 0 within the same cycle; no `done`.
  - A new job started after deassert completes normally.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer
//
// Command-driven control stage for a 4-bit bidirectional shift register. One start
// pulse carries a whole job (seed word, direction, shift count, serial bits). The
// sequencer then emits one load cycle, then the requested number of shift cycles,
// and pulses done. Every output is driven directly from a flop.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-high reset
//   start          job request, accepted only when not busy (IDLE or DONE)
//   cmd_data       seed word for the shift register
//   cmd_dir        shift direction: 0 = right, 1 = left
//   cmd_count      number of shift cycles after the load (clamped to MAX_SHIFT)
//   cmd_bits       serial bits to shift in, bit 0 first
//   load           shift register load strobe
//   serial_input   shift register serial input
//   direction      shift register direction
//   parallel_load  shift register parallel data
//   busy           high during LOAD and SHIFT
//   done           one-cycle pulse when a job completes
//   start_err      one-cycle pulse after a start that arrived while busy
module shift_cmd_sequencer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_SHIFT = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     cmd_data,
  input  logic                 cmd_dir,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic [MAX_SHIFT-1:0] cmd_bits,
  output logic                 load,
  output logic                 serial_input,
  output logic                 direction,
  output logic [WIDTH-1:0]     parallel_load,
  output logic                 busy,
  output logic                 done,
  output logic                 start_err
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_SHIFT);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e state_q, state_d;

  // Captured job. data_q/dir_q double as the parallel_load/direction output flops,
  // which is what makes those outputs hold their last value while idle.
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 dir_q, dir_d;
  logic [MAX_SHIFT-1:0] bits_q, bits_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Number of serial bits already emitted, including the current SHIFT cycle.
  logic [CNT_W-1:0]     idx_q, idx_d;

  logic load_q, load_d;
  logic ser_q, ser_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic accept;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      dir_q   <= 1'b0;
      bits_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      load_q  <= 1'b0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      load_q  <= load_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = (cnt_q == '0) ? StDone : StShift;
      StShift: if (idx_q == cnt_q) state_d = StDone;
      StDone:  state_d = start ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values. Outputs are registered, so they are decoded
  // from the state being entered rather than the current one.
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    bits_d = bits_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    ser_d  = 1'b0;

    if (accept) begin
      data_d = cmd_data;
      dir_d  = cmd_dir;
      bits_d = cmd_bits;
      cnt_d  = (cmd_count > MaxCnt) ? MaxCnt : cmd_count;
      idx_d  = '0;
    end else if (state_d == StShift) begin
      // Bits are consumed LSB first; shifting the copy keeps the next bit at [0].
      ser_d  = bits_q[0];
      bits_d = bits_q >> 1;
      idx_d  = idx_q + 1'b1;
    end

    load_d = (state_d == StLoad);
    busy_d = (state_d == StLoad) || (state_d == StShift);
    done_d = (state_d == StDone);
    err_d  = start && busy_q;
  end

  assign load          = load_q;
  assign serial_input  = ser_q;
  assign direction     = dir_q;
  assign parallel_load = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign start_err     = err_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Testbench for shift_cmd_sequencer. Stimulus pushes the expected per-cycle output
// records of each job into a queue; a monitor pops one record on every active
// cycle and also drives a 4-bit shift-register model from the DUT outputs.
module tb_shift_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic [7:0] cmd_bits;
  logic       load;
  logic       serial_input;
  logic       direction;
  logic [3:0] parallel_load;
  logic       busy;
  logic       done;
  logic       start_err;

  shift_cmd_sequencer #(
    .WIDTH    (4),
    .MAX_SHIFT(8),
    .CNT_W    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cmd_data     (cmd_data),
    .cmd_dir      (cmd_dir),
    .cmd_count    (cmd_count),
    .cmd_bits     (cmd_bits),
    .load         (load),
    .serial_input (serial_input),
    .direction    (direction),
    .parallel_load(parallel_load),
    .busy         (busy),
    .done         (done),
    .start_err    (start_err)
  );

  // Record layout: {load, serial_input, direction, parallel_load[3:0], busy, done, start_err}
  typedef struct {
    int         cyc;
    logic [9:0] outs;
    logic       chk_sr;
    logic [3:0] sr;
  } rec_t;

  rec_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] sr = 4'b0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every active cycle against the next expected record.
  always @(negedge clk) begin
    rec_t       e;
    logic [9:0] act;
    act = {load, serial_input, direction, parallel_load, busy, done, start_err};
    if (!reset && (load || busy || done || start_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got=%b", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.outs !== act) begin
          errors++;
          $display("FAIL cycle_outputs got cyc=%0d outs=%b, want cyc=%0d outs=%b",
                   cyc, act, e.cyc, e.outs);
        end
        if (e.chk_sr) begin
          checks++;
          if (sr !== e.sr) begin
            errors++;
            $display("FAIL shift_reg_final cyc=%0d got=%b want=%b", cyc, sr, e.sr);
          end
        end
      end
    end
    // Shift register model acts at the end of each load/shift cycle.
    if (load) sr = parallel_load;
    else if (busy) sr = direction ? {sr[2:0], serial_input} : {serial_input, sr[3:1]};
  end

  // Push expected records for a job whose LOAD cycle is base. n is the hand-computed
  // effective shift count; err_cyc marks a cycle expected to show start_err.
  task automatic push_job(input logic [3:0] d, input logic r, input int n, input logic [7:0] b,
                          input int base, input int err_cyc, input logic [3:0] srv,
                          input int limit);
    rec_t e;
    for (int k = 0; k < n + 2 && k < limit; k++) begin
      e.cyc    = base + k;
      e.chk_sr = 1'b0;
      e.sr     = srv;
      if (k == 0) e.outs = {1'b1, 1'b0, r, d, 1'b1, 1'b0, 1'b0};
      else if (k <= n) e.outs = {1'b0, b[k-1], r, d, 1'b1, 1'b0, 1'b0};
      else begin
        e.outs   = {1'b0, 1'b0, r, d, 1'b0, 1'b1, 1'b0};
        e.chk_sr = 1'b1;
      end
      if (e.cyc == err_cyc) e.outs[0] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge: issues a one-cycle start, then scrambles cmd_* mid-job.
  task automatic start_job(input logic [3:0] d, input logic r, input logic [3:0] cnt,
                           input logic [7:0] b, input int n, input logic [3:0] srv,
                           input int err_off, input int limit, output int base);
    cmd_data  = d;
    cmd_dir   = r;
    cmd_count = cnt;
    cmd_bits  = b;
    start     = 1'b1;
    base      = cyc + 1;
    push_job(d, r, n, b, base, (err_off < 0) ? -1 : base + err_off, srv, limit);
    @(negedge clk);
    start     = 1'b0;
    cmd_data  = ~d;
    cmd_dir   = ~r;
    cmd_count = 4'd5;
    cmd_bits  = ~b;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d records left, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    logic [9:0] act;
    act = {load, serial_input, direction, parallel_load, busy, done, start_err};
    checks++;
    if (act !== 10'b0) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, act, 10'b0);
    end
  endtask

  initial begin
    int base;
    start     = 1'b0;
    cmd_data  = 4'h0;
    cmd_dir   = 1'b0;
    cmd_count = 4'h0;
    cmd_bits  = 8'h00;
    reset     = 1'b0;
    #1 reset  = 1'b1;
    #1 check_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Right shift: 1010 -> 1101 -> 1110.
    start_job(4'b1010, 1'b0, 4'd2, 8'h03, 2, 4'b1110, -1, 99, base);
    drain("right_shift");

    // Zero count: load only, done two cycles after accept.
    start_job(4'hF, 1'b0, 4'd0, 8'h00, 0, 4'b1111, -1, 99, base);
    drain("zero_count");

    // Clamp 12 -> 8, left; serial 1,0,1,0,0,1,0,1 leaves 0101.
    start_job(4'b0011, 1'b1, 4'd12, 8'hA5, 8, 4'b0101, -1, 99, base);
    drain("clamp");

    // Collision during first SHIFT cycle, then back-to-back start in DONE.
    start_job(4'b0110, 1'b1, 4'd4, 8'h09, 4, 4'b1001, 2, 99, base);
    @(negedge clk);
    cmd_data  = 4'b1111;
    cmd_count = 4'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc != base + 5) @(negedge clk);
    start_job(4'b1001, 1'b0, 4'd1, 8'h00, 1, 4'b0100, -1, 99, base);
    drain("collision_b2b");

    // Reset during the 3rd SHIFT cycle of an 8-shift job.
    start_job(4'hF, 1'b0, 4'd8, 8'hFF, 8, 4'h0, -1, 3, base);
    while (cyc != base + 2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("reset_mid_shift");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drain("reset_mid_shift");

    // Job after reset: left, 0101 -> 1010 -> 0101 -> 1011.
    start_job(4'b0101, 1'b1, 4'd3, 8'h06, 3, 4'b1011, -1, 99, base);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
